// File: rtl/calc_key_sequencer.sv
// Keypad calculator front end: key FIFO, operand/operator parser, ALU
// start/done handshake with timeout, and 7-segment display word.
module calc_key_sequencer #(
  parameter int DIGITS     = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int W          = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic         sw_clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  input  logic [W-1:0] ans,
  input  logic         calc_done,
  input  logic         calc_err,
  output logic [W-1:0] operand1,
  output logic [W-1:0] operand2,
  output logic [2:0]   operator,
  output logic         calc_start,
  output logic [W-1:0] fnd_serial,
  output logic [1:0]   fnd_mode,
  output logic         key_drop,
  output logic [2:0]   state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1) + 1;

  localparam logic [3:0] K_DIV   = 4'hA;
  localparam logic [3:0] K_TIMES = 4'hB;
  localparam logic [3:0] K_SGN   = 4'hC;
  localparam logic [3:0] K_CLR   = 4'hD;
  localparam logic [3:0] K_ANS   = 4'hE;
  localparam logic [3:0] K_EQ    = 4'hF;

  typedef enum logic [2:0] {IDLE, OP1, OPR, OP2, CALC, RESULT, ERROR} state_t;
  typedef enum logic [2:0] {EQU, TIMES, DIV, PLUS, MINUS, MOD} op_t;

  state_t st;
  op_t    op_q, op_next;

  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          empty, full, push, pop;
  logic [3:0]    head;
  logic          is_digit;

  logic          sign_q, ans_flag_q, chain_q;
  logic [W-1:0]  mag_q, last_ans;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmo_q;

  logic          ed_sign, ed_ans;
  logic [W-1:0]  ed_mag, ed_val, entry_val;
  logic [CW-1:0] ed_cnt;
  logic          entry_empty;

  assign empty    = (fifo_cnt == '0);
  assign full     = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign head     = fifo_mem[rd_ptr];
  assign is_digit = (head <= 4'd9);
  assign push     = key_valid && (!full || pop);
  assign operator = op_q;
  assign state    = st;

  assign entry_val   = sign_q ? -mag_q : mag_q;
  assign entry_empty = (cnt_q == '0) && !ans_flag_q;

  // Pop decision depends only on the current head key and FSM context.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (head == K_CLR) pop = 1'b1;
      else begin
        case (st)
          OP1, OP2: pop = is_digit || head == K_SGN || head == K_ANS || head == K_EQ;
          OPR:      pop = !((is_digit || head == K_ANS) && op_q != EQU);
          RESULT:   pop = (head == K_EQ);
          ERROR:    pop = 1'b1;
          default:  pop = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    ed_sign = sign_q;
    ed_mag  = mag_q;
    ed_cnt  = cnt_q;
    ed_ans  = ans_flag_q;
    if (is_digit) begin
      if (!ans_flag_q && cnt_q < (sign_q ? CW'(DIGITS - 1) : CW'(DIGITS))) begin
        ed_mag = mag_q * W'(10) + W'(head);
        ed_cnt = cnt_q + CW'(1);
      end
    end else if (head == K_SGN) begin
      ed_sign = !sign_q;
    end else if (head == K_ANS) begin
      ed_mag = last_ans;
      ed_ans = 1'b1;
    end
    ed_val = ed_sign ? -ed_mag : ed_mag;
  end

  always_comb begin
    op_next = op_q;
    case (head)
      K_DIV:   op_next = (op_q == DIV) ? MOD : DIV;
      K_SGN:   op_next = (op_q == PLUS) ? MINUS : PLUS;
      K_TIMES: op_next = TIMES;
      default: op_next = op_q;
    endcase
  end

  always_ff @(posedge sw_clk) begin
    if (push) fifo_mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge sw_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      st         <= IDLE;
      op_q       <= EQU;
      operand1   <= '0;
      operand2   <= '0;
      calc_start <= 1'b0;
      key_drop   <= 1'b0;
      fnd_serial <= '0;
      fnd_mode   <= 2'd0;
      last_ans   <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      cnt_q      <= '0;
      ans_flag_q <= 1'b0;
      chain_q    <= 1'b0;
      tmo_q      <= '0;
    end else begin
      calc_start <= 1'b0;
      key_drop   <= key_valid && full && !pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (AW+1)'(1);

      if (!empty && head == K_CLR) begin
        st         <= IDLE;
        op_q       <= EQU;
        operand1   <= '0;
        operand2   <= '0;
        sign_q     <= 1'b0;
        mag_q      <= '0;
        cnt_q      <= '0;
        ans_flag_q <= 1'b0;
        chain_q    <= 1'b0;
        fnd_serial <= '0;
        fnd_mode   <= 2'd1;
      end else begin
        case (st)
          IDLE: begin
            fnd_mode   <= 2'd1;
            fnd_serial <= '0;
            if (!empty) st <= OP1;
          end
          OP1, OP2: if (!empty) begin
            if (is_digit || head == K_SGN || head == K_ANS) begin
              sign_q     <= ed_sign;
              mag_q      <= ed_mag;
              cnt_q      <= ed_cnt;
              ans_flag_q <= ed_ans;
              fnd_serial <= ed_val;
              fnd_mode   <= 2'd1;
            end else if (st == OP1 && (head == K_DIV || head == K_TIMES)) begin
              operand1   <= entry_empty ? last_ans : entry_val;
              st         <= OPR;
              fnd_mode   <= 2'd2;
              fnd_serial <= {{(W-3){1'b0}}, op_q};
            end else if (st == OP2 && (head == K_DIV || head == K_TIMES || head == K_EQ)) begin
              operand2   <= entry_val;
              chain_q    <= (head != K_EQ);
              st         <= CALC;
              calc_start <= 1'b1;
              tmo_q      <= '0;
            end
          end
          OPR: if (!empty) begin
            if (head == K_DIV || head == K_TIMES || head == K_SGN) begin
              op_q       <= op_next;
              fnd_serial <= {{(W-3){1'b0}}, op_next};
            end else if ((is_digit || head == K_ANS) && op_q != EQU) begin
              sign_q     <= 1'b0;
              mag_q      <= '0;
              cnt_q      <= '0;
              ans_flag_q <= 1'b0;
              st         <= OP2;
              fnd_mode   <= 2'd1;
              fnd_serial <= '0;
            end
          end
          CALC: begin
            tmo_q <= tmo_q + TW'(1);
            // calc_start is still high in the first CALC cycle; done is not yet accepted
            if (!calc_start) begin
              if (calc_done) begin
                if (calc_err) begin
                  st       <= ERROR;
                  fnd_mode <= 2'd3;
                end else begin
                  last_ans   <= ans;
                  fnd_serial <= ans;
                  if (chain_q) begin
                    operand1 <= ans;
                    op_q     <= EQU;
                    st       <= OPR;
                    fnd_mode <= 2'd2;
                  end else begin
                    st       <= RESULT;
                    fnd_mode <= 2'd1;
                  end
                end
              end else if (tmo_q == TW'(TIMEOUT)) begin
                st       <= ERROR;
                fnd_mode <= 2'd3;
              end
            end
          end
          RESULT: if (!empty) begin
            if (is_digit || head == K_ANS) begin
              if (is_digit) begin
                operand1 <= '0;
                operand2 <= '0;
              end
              op_q       <= EQU;
              sign_q     <= 1'b0;
              mag_q      <= '0;
              cnt_q      <= '0;
              ans_flag_q <= 1'b0;
              st         <= OP1;
            end else if (head == K_DIV || head == K_TIMES || head == K_SGN) begin
              operand1   <= last_ans;
              op_q       <= EQU;
              st         <= OPR;
              fnd_mode   <= 2'd2;
              fnd_serial <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
